// File: rtl/xoodyak_seq_pkg.sv
// rtl/xoodyak_seq_pkg.sv - shared sizes, FSM states and script entry type for the Xoodyak op sequencer
// XOOD_SEQ_CHECK_EN adds the xsel field to each script entry.
package xoodyak_seq_pkg;

  localparam int SEQ_OPW   = 6;
  localparam int SEQ_HW    = 4;
  localparam int SEQ_NDATA = 16;
  localparam int SEQ_DSW   = $clog2(SEQ_NDATA);
  localparam int SEQ_TXW   = 192;

  localparam logic [SEQ_OPW-1:0] OP_IDLE = '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_HOLD,
    ST_DONE
  } seq_state_e;

  typedef struct packed {
    logic [SEQ_OPW-1:0] op;
    logic [SEQ_HW-1:0]  hold;
    logic [SEQ_DSW-1:0] dsel;
`ifdef XOOD_SEQ_CHECK_EN
    logic [SEQ_DSW-1:0] xsel;
`endif
  } seq_entry_t;

  localparam int SEQ_EW = $bits(seq_entry_t);

endpackage

// File: rtl/xoodyak_seq_ram.sv
// rtl/xoodyak_seq_ram.sv - flop array with one synchronous write port and one asynchronous read port
// Contents are deliberately not reset so loaded scripts survive a reset.
module xoodyak_seq_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/xoodyak_op_sequencer.sv
// rtl/xoodyak_op_sequencer.sv - replays a loaded opmode/data script into the Xoodyak core
// XOOD_SEQ_CHECK_EN adds textout comparison against a per-entry reference and a mismatch counter.
module xoodyak_op_sequencer
  import xoodyak_seq_pkg::*;
#(
  parameter int  DEPTH  = 64,
  parameter int  DATA_W = 352,
  localparam int AW     = $clog2(DEPTH),
  localparam int DSW    = SEQ_DSW,
  localparam int OPW    = SEQ_OPW,
  localparam int HW     = SEQ_HW
) (
  input  logic              eph1,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [OPW-1:0]    cfg_op,
  input  logic [HW-1:0]     cfg_hold,
  input  logic [DSW-1:0]    cfg_dsel,
  input  logic              dat_we,
  input  logic [DSW-1:0]    dat_addr,
  input  logic [DATA_W-1:0] dat_wdata,
  input  logic [AW-1:0]     run_last,
  input  logic              run_loop,
  input  logic              start,
  input  logic              abort,
  input  logic              op_ready,
`ifdef XOOD_SEQ_CHECK_EN
  input  logic [DSW-1:0]    cfg_xsel,
  input  logic [191:0]      textout,
  input  logic              textout_valid,
  output logic [15:0]       mismatch_cnt,
`endif
  output logic [OPW-1:0]    opmode,
  output logic [DATA_W-1:0] input_data,
  output logic              op_valid,
  output logic              busy,
  output logic              done,
  output logic [AW-1:0]     entry_idx
);

  seq_state_e        state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [AW-1:0]     last_q, last_d;
  logic              loop_q, loop_d;
  logic [HW-1:0]     hctr_q, hctr_d;
  logic              idle;
  logic              advance;
  logic              script_we;
  logic              data_we;
  seq_entry_t        wr_entry;
  seq_entry_t        cur_entry;
  logic [DATA_W-1:0] cur_data;

  assign idle      = (state_q == ST_IDLE);
  assign script_we = cfg_we & idle;
  assign data_we   = dat_we & idle;

  always_comb begin
    wr_entry      = '0;
    wr_entry.op   = cfg_op;
    wr_entry.hold = cfg_hold;
    wr_entry.dsel = cfg_dsel;
`ifdef XOOD_SEQ_CHECK_EN
    wr_entry.xsel = cfg_xsel;
`endif
  end

  xoodyak_seq_ram #(
    .DEPTH (DEPTH),
    .WIDTH (SEQ_EW)
  ) u_script_ram (
    .clk_i   (eph1),
    .we_i    (script_we),
    .waddr_i (cfg_addr),
    .wdata_i (wr_entry),
    .raddr_i (idx_q),
    .rdata_o (cur_entry)
  );

  xoodyak_seq_ram #(
    .DEPTH (SEQ_NDATA),
    .WIDTH (DATA_W)
  ) u_data_ram (
    .clk_i   (eph1),
    .we_i    (data_we),
    .waddr_i (dat_addr),
    .wdata_i (dat_wdata),
    .raddr_i (cur_entry.dsel),
    .rdata_o (cur_data)
  );

  always_ff @(posedge eph1 or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      last_q  <= '0;
      loop_q  <= 1'b0;
      hctr_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      loop_q  <= loop_d;
      hctr_q  <= hctr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    last_d     = last_q;
    loop_d     = loop_q;
    hctr_d     = hctr_q;
    advance    = 1'b0;
    op_valid   = 1'b0;
    done       = 1'b0;
    opmode     = OP_IDLE;
    input_data = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          last_d  = run_last;
          loop_d  = run_loop;
          idx_d   = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        op_valid   = 1'b1;
        opmode     = cur_entry.op;
        input_data = cur_data;
        if (op_ready) begin
          if (cur_entry.hold != '0) begin
            hctr_d  = cur_entry.hold;
            state_d = ST_HOLD;
          end else begin
            advance = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        opmode     = cur_entry.op;
        input_data = cur_data;
        hctr_d     = hctr_q - HW'(1);
        if (hctr_q == HW'(1)) begin
          advance = 1'b1;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (advance) begin
      if (idx_q != last_q) begin
        idx_d   = idx_q + AW'(1);
        state_d = ST_ISSUE;
      end else if (loop_q) begin
        idx_d   = '0;
        state_d = ST_ISSUE;
      end else begin
        state_d = ST_DONE;
      end
    end

    // Abort overrides any accept/advance decided above, and never pulses done.
    if (abort && !idle) begin
      state_d = ST_IDLE;
      idx_d   = idx_q;
      hctr_d  = hctr_q;
    end
  end

  assign busy      = ~idle;
  assign entry_idx = idx_q;

`ifdef XOOD_SEQ_CHECK_EN
  logic [SEQ_TXW-1:0] xref;
  logic [15:0]        mcnt_q, mcnt_d;

  // Only the top 192 bits of each data word are ever compared, so keep a narrow shadow copy.
  xoodyak_seq_ram #(
    .DEPTH (SEQ_NDATA),
    .WIDTH (SEQ_TXW)
  ) u_xref_ram (
    .clk_i   (eph1),
    .we_i    (data_we),
    .waddr_i (dat_addr),
    .wdata_i (dat_wdata[DATA_W-1 -: SEQ_TXW]),
    .raddr_i (cur_entry.xsel),
    .rdata_o (xref)
  );

  always_comb begin
    mcnt_d = mcnt_q;
    if (idle && start && !abort) begin
      mcnt_d = '0;
    end else if (textout_valid && (textout != xref) && (mcnt_q != 16'hFFFF)) begin
      mcnt_d = mcnt_q + 16'd1;
    end
  end

  always_ff @(posedge eph1 or negedge reset) begin
    if (!reset) begin
      mcnt_q <= '0;
    end else begin
      mcnt_q <= mcnt_d;
    end
  end

  assign mismatch_cnt = mcnt_q;
`endif

endmodule

// File: tb/tb_xoodyak_op_sequencer.sv
// tb/tb_xoodyak_op_sequencer.sv - scoreboard bench for xoodyak_op_sequencer
// XOOD_SEQ_CHECK_EN enables the textout mismatch-counter scenario.
module tb_xoodyak_op_sequencer;
  import xoodyak_seq_pkg::*;

  localparam int DEPTH  = 64;
  localparam int DATA_W = 352;
  localparam int AW     = 6;
  localparam int DSW    = SEQ_DSW;
  localparam int OPW    = SEQ_OPW;
  localparam int HW     = SEQ_HW;

  logic              eph1 = 1'b0;
  logic              reset;
  logic              cfg_we;
  logic [AW-1:0]     cfg_addr;
  logic [OPW-1:0]    cfg_op;
  logic [HW-1:0]     cfg_hold;
  logic [DSW-1:0]    cfg_dsel;
  logic              dat_we;
  logic [DSW-1:0]    dat_addr;
  logic [DATA_W-1:0] dat_wdata;
  logic [AW-1:0]     run_last;
  logic              run_loop;
  logic              start;
  logic              abort;
  logic              op_ready;
  logic [OPW-1:0]    opmode;
  logic [DATA_W-1:0] input_data;
  logic              op_valid;
  logic              busy;
  logic              done;
  logic [AW-1:0]     entry_idx;
`ifdef XOOD_SEQ_CHECK_EN
  logic [DSW-1:0]    cfg_xsel;
  logic [191:0]      textout;
  logic              textout_valid;
  logic [15:0]       mismatch_cnt;
`endif

  xoodyak_op_sequencer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .eph1       (eph1),
    .reset      (reset),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_op     (cfg_op),
    .cfg_hold   (cfg_hold),
    .cfg_dsel   (cfg_dsel),
    .dat_we     (dat_we),
    .dat_addr   (dat_addr),
    .dat_wdata  (dat_wdata),
    .run_last   (run_last),
    .run_loop   (run_loop),
    .start      (start),
    .abort      (abort),
    .op_ready   (op_ready),
`ifdef XOOD_SEQ_CHECK_EN
    .cfg_xsel      (cfg_xsel),
    .textout       (textout),
    .textout_valid (textout_valid),
    .mismatch_cnt  (mismatch_cnt),
`endif
    .opmode     (opmode),
    .input_data (input_data),
    .op_valid   (op_valid),
    .busy       (busy),
    .done       (done),
    .entry_idx  (entry_idx)
  );

  always #5 eph1 = ~eph1;

  typedef struct packed {
    logic [OPW-1:0]    op;
    logic              vld;
    logic              dn;
    logic              bsy;
    logic              in_ent;
    logic [AW-1:0]     idx;
    logic [DATA_W-1:0] dat;
  } exp_t;

  exp_t              exp_q[$];
  logic [OPW-1:0]    m_op   [DEPTH];
  logic [HW-1:0]     m_hold [DEPTH];
  logic [DSW-1:0]    m_dsel [DEPTH];
  logic [DSW-1:0]    m_xsel [DEPTH];
  logic [DATA_W-1:0] m_dat  [SEQ_NDATA];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge eph1);
    #1;
  endtask

  task automatic wr_script(input int a, input logic [OPW-1:0] op, input logic [HW-1:0] h,
                           input logic [DSW-1:0] ds, input logic [DSW-1:0] xs);
    cfg_we   = 1'b1;
    cfg_addr = AW'(a);
    cfg_op   = op;
    cfg_hold = h;
    cfg_dsel = ds;
`ifdef XOOD_SEQ_CHECK_EN
    cfg_xsel = xs;
`endif
    tick();
    cfg_we    = 1'b0;
    m_op[a]   = op;
    m_hold[a] = h;
    m_dsel[a] = ds;
    m_xsel[a] = xs;
  endtask

  task automatic wr_data(input int a, input logic [DATA_W-1:0] w);
    dat_we    = 1'b1;
    dat_addr  = DSW'(a);
    dat_wdata = w;
    tick();
    dat_we    = 1'b0;
    m_dat[a]  = w;
  endtask

  task automatic push_rec(input int k, input logic vld);
    exp_t e;
    e.op     = m_op[k];
    e.vld    = vld;
    e.dn     = 1'b0;
    e.bsy    = 1'b1;
    e.in_ent = 1'b1;
    e.idx    = AW'(k);
    e.dat    = m_dat[m_dsel[k]];
    exp_q.push_back(e);
  endtask

  // An entry offers itself for stall+1 cycles, then sits in hold for m_hold cycles.
  task automatic push_entry(input int k, input int stall);
    for (int s = 0; s <= stall; s++) push_rec(k, 1'b1);
    for (int h = 0; h < int'(m_hold[k]); h++) push_rec(k, 1'b0);
  endtask

  task automatic push_end(input logic with_done);
    exp_t e;
    e = '0;
    if (with_done) begin
      e.dn  = 1'b1;
      e.bsy = 1'b1;
      exp_q.push_back(e);
    end
    e = '0;
    exp_q.push_back(e);
  endtask

  task automatic run_seq(input logic [AW-1:0] last, input logic loop, input int stall,
                         input int abort_at, input int wr_at);
    exp_t e;
    int   i;
    run_last = last;
    run_loop = loop;
    start    = 1'b1;
    tick();
    start = 1'b0;
    i     = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("opmode", opmode, e.op);
      check("op_valid", op_valid, e.vld);
      check("done", done, e.dn);
      check("busy", busy, e.bsy);
      if (e.in_ent) begin
        check("entry_idx", entry_idx, e.idx);
        check("input_data", input_data, e.dat);
      end
      op_ready = (i >= stall);
      abort    = (i == abort_at);
      cfg_we   = (i == wr_at);
      cfg_addr = '0;
      cfg_op   = 6'h16;
      cfg_hold = '0;
      cfg_dsel = '0;
      tick();
      i++;
    end
    abort  = 1'b0;
    cfg_we = 1'b0;
  endtask

  initial begin
    logic [DATA_W-1:0] w;
    reset = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_op = '0; cfg_hold = '0; cfg_dsel = '0;
    dat_we = 1'b0; dat_addr = '0; dat_wdata = '0; run_last = '0; run_loop = 1'b0;
    start = 1'b0; abort = 1'b0; op_ready = 1'b0;
`ifdef XOOD_SEQ_CHECK_EN
    cfg_xsel = '0; textout = '0; textout_valid = 1'b0;
`endif
    repeat (2) @(posedge eph1);
    #1;
    check("rst_opmode", opmode, '0);
    check("rst_op_valid", op_valid, '0);
    check("rst_busy", busy, '0);
    check("rst_done", done, '0);
    check("rst_entry_idx", entry_idx, '0);
    check("rst_input_data", input_data, '0);
`ifdef XOOD_SEQ_CHECK_EN
    check("rst_mismatch_cnt", mismatch_cnt, '0);
`endif
    reset = 1'b1;
    tick();

    for (int a = 0; a < SEQ_NDATA; a++) begin
      for (int j = 0; j < DATA_W / 32; j++) w[j*32 +: 32] = $urandom;
      wr_data(a, w);
    end
    wr_script(0, 6'd1, 4'd0, 4'd5, 4'd7);
    wr_script(1, 6'd2, 4'd3, 4'd2, 4'd3);
    wr_script(2, 6'd3, 4'd0, 4'd9, 4'd12);

    // basic three-entry run: opmode 1,2,2,2,2,3 then done then idle
    push_entry(0, 0); push_entry(1, 0); push_entry(2, 0); push_end(1'b1);
    run_seq(6'd2, 1'b0, 0, -1, -1);

    // op_ready low for 5 cycles on entry 0
    push_entry(0, 5); push_entry(1, 0); push_entry(2, 0); push_end(1'b1);
    run_seq(6'd2, 1'b0, 5, -1, -1);

    // abort during first hold cycle of entry 1
    push_entry(0, 0); push_rec(1, 1'b1); push_rec(1, 1'b0); push_end(1'b0);
    run_seq(6'd2, 1'b0, 0, 2, -1);

    // script write while busy is dropped; rerun still shows op 1 at entry 0
    push_entry(0, 0); push_entry(1, 0); push_entry(2, 0); push_end(1'b1);
    run_seq(6'd2, 1'b0, 0, -1, 1);
    push_entry(0, 0); push_entry(1, 0); push_entry(2, 0); push_end(1'b1);
    run_seq(6'd2, 1'b0, 0, -1, -1);

    // single-entry run
    push_entry(0, 0); push_end(1'b1);
    run_seq(6'd0, 1'b0, 0, -1, -1);

    // looping run 9,19,... ended only by abort
    wr_script(0, 6'd9, 4'd0, 4'd1, 4'd0);
    wr_script(1, 6'd19, 4'd0, 4'd4, 4'd1);
    for (int r = 0; r < 3; r++) begin
      push_entry(0, 0); push_entry(1, 0);
    end
    push_end(1'b0);
    run_seq(6'd1, 1'b1, 0, 5, -1);

    // start and abort together in idle: no run
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("sa_busy", busy, '0);
    check("sa_op_valid", op_valid, '0);
    tick();
    check("sa_busy2", busy, '0);

    // asynchronous reset mid-run, tables must survive
    run_last = 6'd2; run_loop = 1'b0; op_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2;
    reset = 1'b0;
    #1;
    check("ar_busy", busy, '0);
    check("ar_op_valid", op_valid, '0);
    check("ar_opmode", opmode, '0);
    check("ar_entry_idx", entry_idx, '0);
    tick();
    reset = 1'b1;
    tick();
    push_entry(0, 0); push_entry(1, 0); push_entry(2, 0); push_end(1'b1);
    run_seq(6'd2, 1'b0, 0, -1, -1);

`ifdef XOOD_SEQ_CHECK_EN
    wr_script(0, 6'd1, 4'd0, 4'd5, 4'd7);
    wr_script(1, 6'd2, 4'd3, 4'd2, 4'd3);
    wr_script(2, 6'd3, 4'd0, 4'd9, 4'd12);
    run_last = 6'd2; run_loop = 1'b0; op_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    textout_valid = 1'b1;
    textout = m_dat[m_xsel[0]][DATA_W-1 -: 192];
    tick();
    textout = ~m_dat[m_xsel[1]][DATA_W-1 -: 192];
    tick();
    textout_valid = 1'b0;
    repeat (3) tick();
    textout_valid = 1'b1;
    textout = m_dat[m_xsel[2]][DATA_W-1 -: 192] ^ 192'h1;
    tick();
    textout_valid = 1'b0;
    check("mcnt_done", mismatch_cnt, 16'd2);
    tick();
    check("mcnt_idle", mismatch_cnt, 16'd2);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("mcnt_clear", mismatch_cnt, 16'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule
